merge_sequencer: RTL and testbench
==================================

# merge_sequencer

Sequencing controller that lets a bank of N debounced buttons share one registered W-bit adder: the first press selects operand A, the second selects operand B, and the block issues the pair to the adder, waits out its latency and writes the sum back into A's slot. It owns the value register bank and sits between the per-button `pbdebounce` outputs and the shared `adder` instance. One operation is in flight at a time.

## Interface
- N, 10, number of selectable value slots (2..16)
- W, 4, width of each value and of the adder operands/result
- ADD_LAT, 1, adder latency in clock edges from operand change to valid result (0..7)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_pulse  in  N  debounced press pulses, one cycle wide per press
- cancel  in  1  drop a pending operand-A selection
- load_en  in  1  write load_data into slot load_idx
- load_idx  in  clog2(N)  slot index for load
- load_data  in  W  value to load
- add_a  out  W  operand A to shared adder (registered)
- add_b  out  W  operand B to shared adder (registered)
- add_result  in  W  sum from shared adder
- values_flat  out  N*W  slot i occupies bits [i*W+W-1 : i*W]
- sel_valid  out  1  operand A is held
- sel_idx  out  clog2(N)  index of held operand A
- busy  out  1  operation in flight (ISSUE/WAIT)
- done  out  1  one-cycle pulse on the write-back edge
- ovf  out  1  one-cycle pulse with done when the sum wrapped

## Operation
- Reset (async, rst_n low): all slots 0, add_a/add_b 0, sel_valid 0, sel_idx 0, busy 0, done 0, ovf 0, state IDLE, latency counter 0.
- Button arbitration: when several btn_pulse bits are high in one cycle, the lowest index wins; the others are dropped.
- IDLE: load_en has priority (slot[load_idx] <= load_data; load_idx >= N is ignored); otherwise a press at index i sets sel_idx=i, sel_valid=1 -> HAVE_A.
- HAVE_A: cancel (priority over press) -> IDLE, sel_valid=0. A press at index == sel_idx is a deselect -> IDLE. A press at index j != sel_idx registers add_a=slot[sel_idx], add_b=slot[j] -> WAIT with counter=0. load_en is ignored.
- WAIT: busy=1; counter increments each edge; all presses, cancel and load_en are ignored. On the edge where counter == ADD_LAT: slot[sel_idx] <= add_result, done=1, ovf=(add_result < add_a), sel_valid=0 -> IDLE.
- Arithmetic: unsigned, modulo 2^W; ovf is derived purely from the wrap comparison.
- A and B may hold equal values; only the indices must differ.

## Timing
- Press sampled at edge E -> sel_valid high from E.
- B press sampled at edge E0 -> add_a/add_b valid and busy high from E0; both are held constant until write-back.
- Write-back, done and ovf occur at edge E0+ADD_LAT+1; values_flat shows the sum from that edge; busy falls at the same edge.
- Back-to-back: a press in the first cycle after done is accepted normally.
- ADD_LAT=0: write-back at E0+1 (combinational adder path).
- rst_n asserted mid-WAIT aborts the operation immediately; no write-back, and no done pulse after release.

## Test plan
- Basic add (N=10, W=4, ADD_LAT=1): load slot2=3, slot5=4; press 2, then 5 -> done 2 cycles after the B press, slot2=7, slot5=4, ovf=0.
- Wrap: slot0=12, slot1=9; press 0, press 1 -> slot0=5, ovf=1 with done.
- Cancel/deselect: press 3, assert cancel -> sel_valid=0 and no add. Press 3 twice -> IDLE with no add. Slot values unchanged in both cases.
- Busy lockout: during WAIT, pulse btn 7, load_en and cancel -> all are ignored; only the pending write-back occurs and the state is IDLE afterward.
- Simultaneous presses: btn_pulse=0b0000100100 in IDLE -> sel_idx=2.
- Reset mid-WAIT: assert rst_n low during WAIT -> all slots 0 and outputs at their reset values; no done pulse after release.

Source files
------------

// File: rtl/merge_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : merge_sequencer                                               |
// | Purpose  : Lets a bank of N debounced buttons share one registered W-bit |
// |            adder. First press picks operand A, second press picks B; the |
// |            pair is issued to the adder and the sum is written back into  |
// |            A's slot once the adder latency has elapsed.                  |
// | Ports    : clk, rst_n        - clock / async active-low reset            |
// |            btn_pulse[N]      - one-cycle press pulses (lowest index wins)|
// |            cancel            - drop a held operand A                     |
// |            load_en/idx/data  - direct slot write while idle              |
// |            add_a/add_b       - registered operands to the shared adder   |
// |            add_result        - sum returned by the shared adder          |
// |            values_flat       - slot i at bits [i*W+W-1 : i*W]            |
// |            sel_valid/sel_idx - operand A held / its index                |
// |            busy, done, ovf   - in flight / write-back pulse / wrapped    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module merge_sequencer #(
  parameter int N       = 10,
  parameter int W       = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         btn_pulse,
  input  logic                 cancel,
  input  logic                 load_en,
  input  logic [$clog2(N)-1:0] load_idx,
  input  logic [W-1:0]         load_data,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  input  logic [W-1:0]         add_result,
  output logic [N*W-1:0]       values_flat,
  output logic                 sel_valid,
  output logic [$clog2(N)-1:0] sel_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam int IDX_W = $clog2(N);
  // ADD_LAT is bounded to 0..7, so three bits always suffice.
  localparam int CNT_W = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HAVE_A = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  localparam logic [CNT_W-1:0] c_lat       = ADD_LAT[CNT_W-1:0];
  localparam logic [IDX_W:0]   c_num_slots = N[IDX_W:0];

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     slot_q [N];
  logic [W-1:0]     slot_d [N];
  logic [W-1:0]     add_a_q, add_a_d;
  logic [W-1:0]     add_b_q, add_b_d;
  logic             sel_valid_q, sel_valid_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic             w_press_any;
  logic [IDX_W-1:0] w_press_idx;
  logic             w_press_same;
  logic             w_load_ok;
  logic             w_wb;

  // Lowest-index arbitration: scanning downward lets the lowest set bit
  // overwrite any higher one.
  always_comb begin
    w_press_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (btn_pulse[i]) begin
        w_press_idx = IDX_W'(i);
      end
    end
  end

  assign w_press_any  = |btn_pulse;
  assign w_press_same = (w_press_idx == sel_idx_q);
  assign w_load_ok    = ({1'b0, load_idx} < c_num_slots);
  assign w_wb         = (state_q == S_WAIT) && (cnt_q == c_lat);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // A load in the same cycle as a press swallows the press.
        if (!load_en && w_press_any) begin
          state_d = S_HAVE_A;
        end
      end
      S_HAVE_A: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (w_press_any) begin
          state_d = w_press_same ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_wb) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs / datapath
  always_comb begin
    slot_d      = slot_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    ovf_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          if (w_load_ok) begin
            slot_d[load_idx] = load_data;
          end
        end else if (w_press_any) begin
          sel_idx_d   = w_press_idx;
          sel_valid_d = 1'b1;
        end
      end
      S_HAVE_A: begin
        if (cancel) begin
          sel_valid_d = 1'b0;
        end else if (w_press_any) begin
          if (w_press_same) begin
            sel_valid_d = 1'b0;
          end else begin
            add_a_d = slot_q[sel_idx_q];
            add_b_d = slot_q[w_press_idx];
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (w_wb) begin
          slot_d[sel_idx_q] = add_result;
          done_d            = 1'b1;
          // Unsigned modulo add wrapped exactly when the sum is below A.
          ovf_d             = (add_result < add_a_q);
          sel_valid_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        sel_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= '0;
      end
      add_a_q     <= '0;
      add_b_q     <= '0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  generate
    for (genvar g = 0; g < N; g++) begin : g_flat
      assign values_flat[g*W +: W] = slot_q[g];
    end
  endgenerate

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign sel_valid = sel_valid_q;
  assign sel_idx   = sel_idx_q;
  assign busy      = (state_q == S_WAIT);
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_merge_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_merge_sequencer                                            |
// | Purpose  : Directed bench for merge_sequencer with a behavioural model   |
// |            of the slot bank / selection / pending operation and a        |
// |            one-stage registered adder standing in for the shared adder.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_merge_sequencer;

  localparam int N       = 10;
  localparam int W       = 4;
  localparam int ADD_LAT = 1;
  localparam int IDX_W   = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     btn_pulse;
  logic             cancel;
  logic             load_en;
  logic [IDX_W-1:0] load_idx;
  logic [W-1:0]     load_data;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_result;
  logic [N*W-1:0]   values_flat;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             busy;
  logic             done;
  logic             ovf;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  merge_sequencer #(.N(N), .W(W), .ADD_LAT(ADD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_pulse  (btn_pulse),
    .cancel     (cancel),
    .load_en    (load_en),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .values_flat(values_flat),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  // Shared adder stand-in: one register stage (ADD_LAT = 1).
  logic [W-1:0] adder_q = '0;
  always @(posedge clk) adder_q <= add_a + add_b;
  assign add_result = adder_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ------------------------------------------------------------ model
  logic [W-1:0] m_slot [N];
  bit           m_sel_valid, m_busy, m_done, m_ovf;
  int           m_sel;
  logic [W-1:0] m_a, m_b;
  int           m_edge, m_wb_edge, m_j;
  logic [W:0]   m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_slot[i] = '0;
      m_sel_valid = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      m_sel = 0; m_a = '0; m_b = '0; m_edge = 0; m_wb_edge = 0;
    end else begin
      m_edge++;
      m_done = 0;
      m_ovf  = 0;
      m_j    = lowest(btn_pulse);
      if (m_busy) begin
        // The sum lands ADD_LAT+1 edges after the operands were issued.
        if (m_edge == m_wb_edge) begin
          m_sum         = {1'b0, m_a} + {1'b0, m_b};
          m_slot[m_sel] = m_sum[W-1:0];
          m_done        = 1;
          m_ovf         = m_sum[W];
          m_busy        = 0;
          m_sel_valid   = 0;
        end
      end else if (!m_sel_valid) begin
        if (load_en) begin
          if (int'(load_idx) < N) m_slot[load_idx] = load_data;
        end else if (m_j >= 0) begin
          m_sel = m_j;
          m_sel_valid = 1;
        end
      end else begin
        if (cancel) m_sel_valid = 0;
        else if (m_j >= 0) begin
          if (m_j == m_sel) m_sel_valid = 0;
          else begin
            m_a       = m_slot[m_sel];
            m_b       = m_slot[m_j];
            m_busy    = 1;
            m_wb_edge = m_edge + ADD_LAT + 1;
          end
        end
      end
    end
  end

  logic [N*W-1:0] exp_flat;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) exp_flat[i*W +: W] = m_slot[i];
      chk("values_flat", values_flat, exp_flat);
      chk("sel_valid", sel_valid, m_sel_valid);
      chk("sel_idx", sel_idx, m_sel[IDX_W-1:0]);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("ovf", ovf, m_ovf);
      chk("add_a", add_a, m_a);
      chk("add_b", add_b, m_b);
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic step(input logic [N-1:0] b, input logic c, input logic le,
                      input int li, input int ld);
    @(posedge clk);
    #2;
    btn_pulse = b;
    cancel    = c;
    load_en   = le;
    load_idx  = li[IDX_W-1:0];
    load_data = ld[W-1:0];
  endtask

  task automatic idle();
    step('0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic press(input int i);
    logic [N-1:0] b;
    b    = '0;
    b[i] = 1'b1;
    step(b, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic load(input int i, input int d);
    step('0, 1'b0, 1'b1, i, d);
  endtask

  function automatic logic [W-1:0] slot(input int i);
    return values_flat[i*W +: W];
  endfunction

  // Counts negedges until done is seen; bounded so a missing done still ends.
  task automatic wait_done(input int exp_k, input string name);
    bit seen;
    int found;
    seen  = 0;
    found = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen  = 1;
        found = k;
      end
    end
    chk({name, "_done_seen"}, seen, 1);
    if (seen) chk({name, "_done_latency"}, found, exp_k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int done_cnt;

  initial begin
    rst_n = 1'b0; btn_pulse = '0; cancel = 1'b0; load_en = 1'b0;
    load_idx = '0; load_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_values", values_flat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel_valid", sel_valid, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Basic add: 3 + 4 into slot 2; done visible 3 negedges after B drive.
    load(2, 3); load(5, 4); press(2); press(5); idle();
    wait_done(3, "basic");
    chk("basic_slot2", slot(2), 7);
    chk("basic_slot5", slot(5), 4);
    chk("basic_ovf", ovf, 0);

    // Wrap: 12 + 9 = 21 -> 5 with ovf.
    load(0, 12); load(1, 9); press(0); press(1); idle();
    wait_done(3, "wrap");
    chk("wrap_slot0", slot(0), 5);
    chk("wrap_ovf", ovf, 1);
    // Back-to-back: press during the done cycle is accepted.
    btn_pulse = '0;
    btn_pulse[8] = 1'b1;
    idle();
    @(negedge clk);
    chk("b2b_sel_valid", sel_valid, 1);
    chk("b2b_sel_idx", sel_idx, 8);
    step('0, 1'b1, 1'b0, 0, 0); idle();

    // Cancel and deselect.
    press(3); step('0, 1'b1, 1'b0, 0, 0); idle();
    @(negedge clk);
    chk("cancel_sel_valid", sel_valid, 0);
    chk("cancel_busy", busy, 0);
    press(3); press(3); idle();
    @(negedge clk);
    chk("deselect_sel_valid", sel_valid, 0);
    chk("deselect_slot3", slot(3), 0);

    // Out-of-range load still wins over a simultaneous press.
    step(10'b0000000010, 1'b0, 1'b1, 12, 9); idle();
    @(negedge clk);
    chk("oor_load_sel_valid", sel_valid, 0);

    // Busy lockout: 5 + 6 into slot 4; press/load/cancel during WAIT ignored.
    load(4, 5); load(6, 6); press(4); press(6);
    step(10'b0010000000, 1'b1, 1'b1, 9, 15); idle();
    wait_done(2, "lockout");
    chk("lockout_slot4", slot(4), 11);
    chk("lockout_slot9", slot(9), 0);
    idle();
    @(negedge clk);
    chk("lockout_busy", busy, 0);
    chk("lockout_sel_valid", sel_valid, 0);

    // Simultaneous presses: lowest index wins.
    step(10'b0000100100, 1'b0, 1'b0, 0, 0); idle();
    @(negedge clk);
    chk("simul_sel_idx", sel_idx, 2);
    step('0, 1'b1, 1'b0, 0, 0); idle();

    // Reset mid-WAIT.
    press(2); press(5);
    @(posedge clk); #2;
    btn_pulse = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_values", values_flat, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_add_a", add_a, 0);
    chk("midrst_add_b", add_b, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_slot2", slot(2), 0);

    repeat (2) idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
